frame_ram_writer: RTL and testbench
===================================

// Module: frame_ram_writer
// PURPOSE
//  Write side of the scaler frame RAM: takes the camera/decoder pixel stream (vsync/de/RGB565), decimates
//  it by a power of two and writes a COL_PIXEL x ROW_PIXEL frame into the 16-bit-addressed RAM that the
//  scaler reads (addr = y*COL_PIXEL + x). Sits between the video input and the frame RAM.
// PARAMETERS
//  COL_PIXEL  320  stored frame width (pixels)
//  ROW_PIXEL  180  stored frame height (lines); COL_PIXEL*ROW_PIXEL must be <= 65536
//  DECIM_SH   2    decimation shift: keep 1 of every 2**DECIM_SH pixels and lines (0 = no decimation)
// PORTS
//  clk         in   1   pixel clock, rising edge
//  rst         in   1   asynchronous reset, active-high
//  cap_en      in   1   capture enable, sampled only at frame start
//  vsync       in   1   frame sync, active-high; rising edge = frame start
//  de          in   1   pixel valid (active video)
//  pix_in      in   16  RGB565 pixel, valid when de=1
//  wr_en       out  1   RAM write strobe
//  wr_addr     out  16  RAM write address
//  wr_data     out  16  RAM write data
//  wr_bank     out  1   bank being written (see CONFIGURATION)
//  rd_bank     out  1   bank holding the last complete frame (see CONFIGURATION)
//  frame_done  out  1   1-cycle pulse: complete frame written
//  frame_err   out  1   sticky: a captured frame ended short (fewer than ROW_PIXEL lines written)
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; x/y/input counters 0.
//  - vsync edge detect on a registered copy; de falling edge = end of input line.
//  - FSM: IDLE -> (vsync rise & cap_en) ARMED; (vsync rise & !cap_en) stays IDLE.
//    ARMED -> first de=1 -> ACTIVE. ACTIVE -> stored y reaches ROW_PIXEL -> DONE.
//    ACTIVE -> vsync rise before ROW_PIXEL lines -> frame_err<=1, no frame_done, re-evaluate cap_en
//    as a fresh frame start (ARMED or IDLE). DONE -> frame_done=1 for one cycle -> IDLE.
//  - Input counters: in_x counts de pixels in a line, clears on de fall; in_y counts input lines
//    in frame, clears at vsync rise.
//  - A pixel is kept when in_x[DECIM_SH-1:0]==0, in_y[DECIM_SH-1:0]==0, in ACTIVE and x<COL_PIXEL.
//    Kept pixel -> next cycle wr_en=1, wr_data=pix_in, wr_addr=y*COL_PIXEL+x (running adder, no multiplier);
//    x increments. Latency pix_in -> wr_en exactly 1 cycle.
//  - Line end (de fall) on a kept line with x>0: y increments, x clears. Pixels beyond COL_PIXEL in a line
//    are dropped; short lines (x<COL_PIXEL) still advance y, unwritten addresses keep old contents.
//  - wr_addr never exceeds COL_PIXEL*ROW_PIXEL-1; lines after ROW_PIXEL are ignored until next vsync.
//  - de asserted while vsync high is ignored. vsync rise and de in same cycle: vsync wins, pixel dropped.
//  - cap_en dropping mid-frame has no effect until the next frame start.
//  - frame_err clears only on rst. Reset mid-frame aborts writes immediately (wr_en=0 asynchronously).
// CONFIGURATION
//  FRAME_PINGPONG_EN defined: two RAM banks; wr_bank selects target bank. On frame_done rd_bank<=wr_bank
//    and wr_bank toggles in the same cycle; an aborted (short) frame does not swap. Reset: wr_bank=0, rd_bank=1.
//  Not defined: single bank; wr_bank and rd_bank tied 0; reader sees tearing during capture.
// TESTING
//  1 1280x720 frame, DECIM_SH=2, cap_en=1 -> 57600 writes, addr 0..57599 in order, frame_done once.
//  2 Pixel pattern pix=in_x|(in_y<<11)-style counter -> RAM at addr 321 holds input pixel (x=4,y=4).
//  3 cap_en=0 at vsync, raised mid-frame -> zero writes that frame; next frame captured fully.
//  4 vsync after 100 kept lines -> frame_err=1, no frame_done, last addr written 31999, next frame restarts at 0.
//  5 1400-pixel lines -> x saturates, no write with x>=320, addr never exceeds 57599.
//  6 FRAME_PINGPONG_EN, two full frames -> wr_bank 0->1->0, rd_bank 1->0->1; rst mid-frame -> outputs 0.

Source files
------------

// File: rtl/frame_ram_writer.sv
// Purpose: decimate a vsync/de/RGB565 pixel stream and write a COL_PIXEL x ROW_PIXEL frame into RAM.
// Latency: exactly 1 cycle from a kept pix_in sample to its wr_en/wr_addr/wr_data strobe.
// Backpressure: none; the RAM must accept a write on every cycle. Optional FRAME_PINGPONG_EN adds bank swap.
module frame_ram_writer #(
    parameter int COL_PIXEL = 320,
    parameter int ROW_PIXEL = 180,
    parameter int DECIM_SH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic        vsync,
    input  logic        de,
    input  logic [15:0] pix_in,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        wr_bank,
    output logic        rd_bank,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [16:0] COL_W = 17'(COL_PIXEL);
    localparam logic [16:0] ROW_W = 17'(ROW_PIXEL);
    // Low DECIM_SH bits of the input counters; a zero mask means every pixel and line is kept.
    localparam logic [15:0] DMASK = 16'((1 << DECIM_SH) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t      state_q,    state_d;
    logic        vsync_q,    vsync_d;
    logic        de_q,       de_d;
    logic [15:0] in_x_q,     in_x_d;
    logic [15:0] in_y_q,     in_y_d;
    logic [16:0] x_q,        x_d;
    logic [16:0] y_q,        y_d;
    logic [16:0] row_base_q, row_base_d;
    logic        wr_en_q,    wr_en_d;
    logic [15:0] wr_addr_q,  wr_addr_d;
    logic [15:0] wr_data_q,  wr_data_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q,  frame_err_d;

    // Pixels presented while vsync is high never count as active video.
    logic de_act;
    logic vsync_rise;
    logic de_fall;
    logic capturing;
    logic keep;
    logic line_done;
    logic last_line;

    assign de_act     = de & ~vsync;
    assign vsync_rise = vsync & ~vsync_q;
    assign de_fall    = de_q & ~de_act;
    assign capturing  = (state_q == S_ARMED) || (state_q == S_ACTIVE);
    assign keep       = de_act && capturing
                        && ((in_x_q & DMASK) == 16'd0)
                        && ((in_y_q & DMASK) == 16'd0)
                        && (x_q < COL_W);
    // x only becomes non-zero on a kept line, so x>0 at de fall marks a stored line.
    assign line_done  = de_fall && capturing && (x_q != 17'd0);
    assign last_line  = line_done && (y_q == ROW_W - 17'd1);

`ifdef FRAME_PINGPONG_EN
    logic wr_bank_q, wr_bank_d;
    logic rd_bank_q, rd_bank_d;
`endif

    // Next-state logic: input counters, write address generation, frame FSM and bank control.
    always_comb begin
        state_d      = state_q;
        vsync_d      = vsync;
        de_d         = de_act;
        in_x_d       = de_act ? in_x_q + 16'd1 : 16'd0;
        in_y_d       = in_y_q;
        x_d          = x_q;
        y_d          = y_q;
        row_base_d   = row_base_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;
`ifdef FRAME_PINGPONG_EN
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
`endif

        if (de_fall) begin
            in_y_d = in_y_q + 16'd1;
        end

        // Address is the running row base plus column; row base steps by COL_PIXEL per stored line.
        if (keep) begin
            wr_en_d   = 1'b1;
            wr_data_d = pix_in;
            wr_addr_d = 16'(row_base_q + x_q);
            x_d       = x_q + 17'd1;
        end

        if (de_fall) begin
            x_d = 17'd0;
        end
        if (line_done) begin
            y_d        = y_q + 17'd1;
            row_base_d = row_base_q + COL_W;
        end

        // Frame start restarts every position counter regardless of FSM state.
        if (vsync_rise) begin
            in_y_d     = 16'd0;
            x_d        = 17'd0;
            y_d        = 17'd0;
            row_base_d = 17'd0;
        end

        case (state_q)
            S_IDLE: begin
                if (vsync_rise && cap_en) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (vsync_rise) begin
                    state_d = cap_en ? S_ARMED : S_IDLE;
                end else if (de_act) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (vsync_rise) begin
                    // Frame ended short: flag it, no done pulse, treat as a fresh frame start.
                    frame_err_d = 1'b1;
                    state_d     = cap_en ? S_ARMED : S_IDLE;
                end else if (last_line) begin
                    state_d      = S_DONE;
                    frame_done_d = 1'b1;
`ifdef FRAME_PINGPONG_EN
                    rd_bank_d    = wr_bank_q;
                    wr_bank_d    = ~wr_bank_q;
`endif
                end
            end
            S_DONE: begin
                state_d = (vsync_rise && cap_en) ? S_ARMED : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any write in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            de_q         <= 1'b0;
            in_x_q       <= 16'd0;
            in_y_q       <= 16'd0;
            x_q          <= 17'd0;
            y_q          <= 17'd0;
            row_base_q   <= 17'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 16'd0;
            wr_data_q    <= 16'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef FRAME_PINGPONG_EN
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            de_q         <= de_d;
            in_x_q       <= in_x_d;
            in_y_q       <= in_y_d;
            x_q          <= x_d;
            y_q          <= y_d;
            row_base_q   <= row_base_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
`ifdef FRAME_PINGPONG_EN
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
`endif
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

`ifdef FRAME_PINGPONG_EN
    assign wr_bank = wr_bank_q;
    assign rd_bank = rd_bank_q;
`else
    // Single bank: the reader always sees the bank under capture.
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

endmodule

// File: tb/tb_frame_ram_writer.sv
// Bench for frame_ram_writer on a scaled-down frame (16x6 stored, 64x24 input, 4:1 decimation).
// Expected RAM writes are derived per frame from the input geometry and queued before driving.
// Writes are popped and compared on the falling edge; bank checks follow FRAME_PINGPONG_EN.
module tb_frame_ram_writer;

    localparam int COL = 16;
    localparam int ROW = 6;
    localparam int SH  = 2;
    localparam int DEC = 1 << SH;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_en;
    logic        vsync;
    logic        de;
    logic [15:0] pix_in;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_bank;
    logic        rd_bank;
    logic        frame_done;
    logic        frame_err;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] dat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [0:COL*ROW-1];
    logic [15:0] prev_pix;
    int          n_vec  = 0;
    int          n_err  = 0;
    int          done_cnt = 0;
    int          frames_ok = 0;

    frame_ram_writer #(
        .COL_PIXEL (COL),
        .ROW_PIXEL (ROW),
        .DECIM_SH  (SH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (cap_en),
        .vsync      (vsync),
        .de         (de),
        .pix_in     (pix_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_bank    (wr_bank),
        .rd_bank    (rd_bank),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pat(input int lx, input int ly);
        return 16'(lx) | 16'(ly << 11);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Input sample seen by the DUT at each rising edge, for the 1-cycle latency check.
    always @(posedge clk) prev_pix <= pix_in;

    // Write monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en === 1'b1) begin
            chk("wr_unexpected", 32'(wr_en), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.dat));
            end
            chk("wr_latency", 32'(wr_data), 32'(prev_pix));
            if (int'(wr_addr) < COL*ROW) mem[wr_addr] = wr_data;
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic check_banks(input string tag);
`ifdef FRAME_PINGPONG_EN
        chk({tag, "_wr_bank"}, 32'(wr_bank), 32'(frames_ok % 2));
        chk({tag, "_rd_bank"}, 32'(rd_bank), 32'(1 - (frames_ok % 2)));
`else
        chk({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
        chk({tag, "_rd_bank"}, 32'(rd_bank), 32'd0);
`endif
    endtask

    // One input frame: vsync pulse (with de held high to prove it is ignored), then active lines.
    task automatic run_frame(input bit cap_start, input bit cap_mid, input int lines, input int width);
        exp_t e;
        if (cap_start) begin
            for (int ly = 0; ly < lines; ly += DEC) begin
                if (ly / DEC < ROW) begin
                    for (int lx = 0; lx < width; lx += DEC) begin
                        if (lx / DEC < COL) begin
                            e.addr = 16'((ly / DEC) * COL + lx / DEC);
                            e.dat  = pat(lx, ly);
                            sb.push_back(e);
                        end
                    end
                end
            end
        end
        cap_en = cap_start;
        vsync  = 1'b1;
        de     = 1'b1;
        pix_in = 16'hdead;
        repeat (3) tick();
        vsync  = 1'b0;
        de     = 1'b0;
        pix_in = 16'h0000;
        repeat (3) tick();
        for (int ly = 0; ly < lines; ly++) begin
            if (ly == 1) cap_en = cap_mid;
            for (int lx = 0; lx < width; lx++) begin
                de     = 1'b1;
                pix_in = pat(lx, ly);
                tick();
            end
            de     = 1'b0;
            pix_in = 16'h0000;
            repeat (4) tick();
        end
        repeat (4) tick();
    endtask

    initial begin
        exp_t e;
        rst    = 1'b1;
        cap_en = 1'b0;
        vsync  = 1'b0;
        de     = 1'b0;
        pix_in = 16'h0000;
        for (int i = 0; i < COL*ROW; i++) mem[i] = 16'hffff;
        #23;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        check_banks("rst");
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Full frame: every stored address written in order, one done pulse.
        run_frame(1'b1, 1'b1, ROW * DEC, COL * DEC);
        frames_ok++;
        chk("f1_sb_empty", 32'(sb.size()), 32'd0);
        chk("f1_done", 32'(done_cnt), 32'd1);
        chk("f1_err", 32'(frame_err), 32'd0);
        chk("f1_mem_col1", 32'(mem[COL+1]), 32'(pat(4, 4)));
        chk("f1_mem_last", 32'(mem[COL*ROW-1]), 32'(pat((COL-1)*DEC, (ROW-1)*DEC)));
        check_banks("f1");

        // cap_en low at frame start, raised mid-frame: nothing written.
        run_frame(1'b0, 1'b1, ROW * DEC, COL * DEC);
        chk("nocap_sb_empty", 32'(sb.size()), 32'd0);
        chk("nocap_done", 32'(done_cnt), 32'd1);
        check_banks("nocap");

        // Next frame captured fully.
        run_frame(1'b1, 1'b1, ROW * DEC, COL * DEC);
        frames_ok++;
        chk("f2_done", 32'(done_cnt), 32'd2);
        check_banks("f2");

        // Short frame: 3 stored lines, then a new vsync arrives.
        run_frame(1'b1, 1'b1, 3 * DEC, COL * DEC);
        chk("short_sb_empty", 32'(sb.size()), 32'd0);
        chk("short_err_pre", 32'(frame_err), 32'd0);
        chk("short_done", 32'(done_cnt), 32'd2);
        run_frame(1'b1, 1'b1, ROW * DEC, COL * DEC);
        frames_ok++;
        chk("short_err_post", 32'(frame_err), 32'd1);
        chk("after_short_done", 32'(done_cnt), 32'd3);
        check_banks("after_short");

        // Over-long lines: columns beyond COL dropped.
        run_frame(1'b1, 1'b1, ROW * DEC, 100);
        frames_ok++;
        chk("wide_sb_empty", 32'(sb.size()), 32'd0);
        chk("wide_done", 32'(done_cnt), 32'd4);

        // Short lines: rows still advance.
        run_frame(1'b1, 1'b1, ROW * DEC, 40);
        frames_ok++;
        chk("narrow_sb_empty", 32'(sb.size()), 32'd0);
        chk("narrow_done", 32'(done_cnt), 32'd5);
        chk("err_sticky", 32'(frame_err), 32'd1);
        check_banks("narrow");

        // Reset in the middle of a line while a write strobe is high.
        cap_en = 1'b1;
        vsync  = 1'b1;
        repeat (3) tick();
        vsync  = 1'b0;
        repeat (3) tick();
        for (int lx = 0; lx <= 8; lx += DEC) begin
            e.addr = 16'(lx / DEC);
            e.dat  = pat(lx, 0);
            sb.push_back(e);
        end
        for (int lx = 0; lx <= 8; lx++) begin
            de     = 1'b1;
            pix_in = pat(lx, 0);
            tick();
        end
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
        chk("midrst_wr_data", 32'(wr_data), 32'd0);
        chk("midrst_frame_err", 32'(frame_err), 32'd0);
        frames_ok = 0;
        check_banks("midrst");
        sb.delete();
        de     = 1'b0;
        pix_in = 16'h0000;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Recovery frame after reset starts again from address 0.
        done_cnt = 0;
        run_frame(1'b1, 1'b1, ROW * DEC, COL * DEC);
        frames_ok++;
        chk("rec_sb_empty", 32'(sb.size()), 32'd0);
        chk("rec_done", 32'(done_cnt), 32'd1);
        chk("rec_err", 32'(frame_err), 32'd0);
        check_banks("rec");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
